riego_multicanal: RTL and testbench

Multi-channel watering controller that extends the single-plant, combinational "should this plant be watered" decision. It serves N_CANALES plants from one shared pump through per-channel valves, with per-plant-type thresholds and hysteresis. A state machine adds round-robin arbitration, a maximum pump-on time with sticky fault, and a mandatory rest period. It sits between the BCD humidity sensor front-end and the pump/valve drivers.

---
 rtl/riego_multicanal.sv | 149 ++++++++++++++
 tb/tb_riego_multicanal.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/riego_multicanal.sv
// Multi-channel watering controller: one shared pump, one valve per plant, round-robin
// arbitration between requesting channels, pump-on timeout with sticky fault, and a rest period.
module riego_multicanal #(
    parameter int N_CANALES = 4,
    parameter int T_RIEGO   = 8,
    parameter int T_ESPERA  = 4,
    parameter int HIST      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      habilitar,
    input  logic [12*N_CANALES-1:0]   humedad,
    input  logic [4*N_CANALES-1:0]    tipoPlanta,
    output logic                      bomba,
    output logic [N_CANALES-1:0]      valvula,
    output logic [N_CANALES-1:0]      falla,
    output logic                      ocupado
);

    localparam int IW   = $clog2(N_CANALES);
    localparam int TMAX = (T_RIEGO > T_ESPERA) ? T_RIEGO : T_ESPERA;
    localparam int CW   = $clog2(TMAX) + 1;

    typedef enum logic [1:0] {REPOSO, REGANDO, ESPERA} estado_t;

    estado_t              estado, estado_sig;
    logic [IW-1:0]        canal, canal_sig, puntero, puntero_sig, elegido, canal_siguiente;
    logic [CW-1:0]        contador, contador_sig;
    logic [N_CANALES-1:0] falla_sig, peticion, valvula_sig;
    logic                 hay_peticion, parar, bomba_sig, ocupado_sig;
    logic [11:0]          h_act;
    logic [3:0]           t_act, umbral_act;

    function automatic logic [3:0] umbral_de(input logic [3:0] tipo);
        if (tipo >= 4'd1 && tipo <= 4'd4) return tipo;
        return 4'd0;
    endfunction

    function automatic logic bcd_valido(input logic [11:0] h);
        return (h[11:8] <= 4'd9) && (h[7:4] <= 4'd9) && (h[3:0] <= 4'd9);
    endfunction

    function automatic logic pide(input logic [11:0] h, input logic [3:0] tipo, input logic f);
        logic [3:0] u;
        u = umbral_de(tipo);
        return bcd_valido(h) && (u != 4'd0) && (h[11:8] == 4'd0) && (h[7:4] < u) && !f;
    endfunction

    always_comb begin
        for (int i = 0; i < N_CANALES; i++)
            peticion[i] = pide(humedad[12*i +: 12], tipoPlanta[4*i +: 4], falla[i]);
    end

    // Scan from the highest offset down so the lowest offset from puntero wins.
    always_comb begin
        logic [IW-1:0] idx;
        idx          = '0;
        elegido      = puntero;
        hay_peticion = |peticion;
        for (int k = N_CANALES - 1; k >= 0; k--) begin
            idx = IW'((int'(puntero) + k) % N_CANALES);
            if (peticion[idx]) elegido = idx;
        end
    end

    always_comb begin
        h_act = '0;
        t_act = '0;
        for (int i = 0; i < N_CANALES; i++) begin
            if (canal == IW'(i)) begin
                h_act = humedad[12*i +: 12];
                t_act = tipoPlanta[4*i +: 4];
            end
        end
        umbral_act      = umbral_de(t_act);
        parar           = !bcd_valido(h_act) || (h_act[11:8] != 4'd0) ||
                          ({1'b0, h_act[7:4]} >= ({1'b0, umbral_act} + 5'(HIST)));
        canal_siguiente = (canal == IW'(N_CANALES - 1)) ? '0 : canal + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado   <= REPOSO;
            canal    <= '0;
            puntero  <= '0;
            contador <= '0;
            falla    <= '0;
        end else begin
            estado   <= estado_sig;
            canal    <= canal_sig;
            puntero  <= puntero_sig;
            contador <= contador_sig;
            falla    <= falla_sig;
        end
    end

    // Stop and enable-drop take priority over the timeout, so a race never sets a fault.
    always_comb begin
        estado_sig   = estado;
        canal_sig    = canal;
        puntero_sig  = puntero;
        contador_sig = contador;
        falla_sig    = falla;
        case (estado)
            REPOSO: begin
                if (habilitar && hay_peticion) begin
                    canal_sig    = elegido;
                    contador_sig = '0;
                    estado_sig   = REGANDO;
                end
            end
            REGANDO: begin
                if (!habilitar || parar || contador == CW'(T_RIEGO - 1)) begin
                    if (habilitar && !parar)
                        falla_sig = falla | (N_CANALES'(1) << canal);
                    contador_sig = '0;
                    puntero_sig  = canal_siguiente;
                    estado_sig   = ESPERA;
                end else begin
                    contador_sig = contador + 1'b1;
                end
            end
            ESPERA: begin
                if (contador == CW'(T_ESPERA - 1)) estado_sig = REPOSO;
                else contador_sig = contador + 1'b1;
            end
            default: estado_sig = REPOSO;
        endcase
    end

    always_comb begin
        bomba_sig   = (estado == REGANDO);
        valvula_sig = bomba_sig ? (N_CANALES'(1) << canal) : '0;
        ocupado_sig = (estado != REPOSO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bomba   <= 1'b0;
            valvula <= '0;
            ocupado <= 1'b0;
        end else begin
            bomba   <= bomba_sig;
            valvula <= valvula_sig;
            ocupado <= ocupado_sig;
        end
    end

endmodule

// File: tb/tb_riego_multicanal.sv
// Directed bench for riego_multicanal: reset, round robin, hysteresis, timeout fault,
// invalid inputs, enable abort, stop/timeout races and mid-watering reset.
module tb_riego_multicanal;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            habilitar;
    logic [12*N-1:0] humedad;
    logic [4*N-1:0]  tipoPlanta;
    logic            bomba;
    logic [N-1:0]    valvula;
    logic [N-1:0]    falla;
    logic            ocupado;

    int checks   = 0;
    int failures = 0;

    riego_multicanal #(.N_CANALES(N), .T_RIEGO(8), .T_ESPERA(4), .HIST(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .habilitar  (habilitar),
        .humedad    (humedad),
        .tipoPlanta (tipoPlanta),
        .bomba      (bomba),
        .valvula    (valvula),
        .falla      (falla),
        .ocupado    (ocupado)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [11:0] h, input logic [3:0] t);
        humedad[12*i +: 12]  = h;
        tipoPlanta[4*i +: 4] = t;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) set_ch(i, 12'h050, 4'd0);
    endtask

    task automatic do_reset();
        idle_all();
        habilitar = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_bomba(input logic level, input string tag, output int n);
        n = 0;
        while (bomba !== level && n < 40) begin
            tick();
            n++;
        end
        check(tag, {31'd0, bomba}, {31'd0, level});
    endtask

    task automatic timeout_race(input logic por_hab, input string tag);
        int n;
        do_reset();
        set_ch(0, 12'h010, 4'd4);
        wait_bomba(1'b1, {tag, "_start"}, n);
        for (int c = 0; c < 6; c++) tick();
        if (por_hab) habilitar = 1'b0;
        else set_ch(0, 12'h050, 4'd4);
        tick();
        check({tag, "_last_on"}, {31'd0, bomba}, 32'd1);
        tick();
        check({tag, "_off"}, {31'd0, bomba}, 32'd0);
        check({tag, "_falla"}, {28'd0, falla}, 32'd0);
        habilitar = 1'b1;
    endtask

    initial begin
        int n, on, highs;
        rst = 1'b1;
        habilitar = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, 12'h010, 4'd4);

        tick();
        tick();
        check("rst_bomba", {31'd0, bomba}, 32'd0);
        check("rst_valvula", {28'd0, valvula}, 32'd0);
        check("rst_falla", {28'd0, falla}, 32'd0);
        check("rst_ocupado", {31'd0, ocupado}, 32'd0);
        rst = 1'b0;
        tick();
        check("rel_edge1_bomba", {31'd0, bomba}, 32'd0);
        tick();
        check("rel_edge2_bomba", {31'd0, bomba}, 32'd1);

        // Round robin with a 5-cycle pump-off gap between waterings.
        for (int k = 0; k < N; k++) begin
            if (k > 0) begin
                wait_bomba(1'b1, "rr_on", n);
                check("rr_gap", n, 32'd5);
            end
            check("rr_valvula", {28'd0, valvula}, 32'(1 << k));
            set_ch(k, 12'h050, 4'd4);
            wait_bomba(1'b0, "rr_off", n);
        end
        check("rr_falla", {28'd0, falla}, 32'd0);

        // Hysteresis: start below 30%, keep going at 35%, stop at 40%.
        do_reset();
        set_ch(2, 12'h025, 4'd3);
        wait_bomba(1'b1, "hys_on", n);
        check("hys_latency", n, 32'd2);
        check("hys_valvula", {28'd0, valvula}, 32'h4);
        set_ch(2, 12'h035, 4'd3);
        tick();
        tick();
        check("hys_still_on", {31'd0, bomba}, 32'd1);
        set_ch(2, 12'h040, 4'd3);
        tick();
        check("hys_stop_edge", {31'd0, bomba}, 32'd1);
        tick();
        check("hys_off", {31'd0, bomba}, 32'd0);
        check("hys_falla", {28'd0, falla}, 32'd0);

        // Timeout: pump on for exactly 8 cycles, then channel 1 is faulted and ignored.
        do_reset();
        set_ch(1, 12'h005, 4'd2);
        wait_bomba(1'b1, "to_on", n);
        check("to_valvula", {28'd0, valvula}, 32'h2);
        on = 1;
        while (bomba && on < 30) begin
            tick();
            if (bomba) on++;
        end
        check("to_on_cycles", on, 32'd8);
        check("to_falla", {28'd0, falla}, 32'h2);
        tick();
        tick();
        tick();
        check("to_espera_busy", {31'd0, ocupado}, 32'd1);
        tick();
        check("to_espera_done", {31'd0, ocupado}, 32'd0);
        highs = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bomba) highs++;
        end
        check("to_excluded", highs, 32'd0);
        do_reset();
        check("to_rst_clears", {28'd0, falla}, 32'd0);

        // Invalid or unused inputs never request; an invalid digit stops watering.
        do_reset();
        set_ch(0, 12'h000, 4'd0);
        set_ch(1, 12'h000, 4'd7);
        set_ch(2, 12'h0A0, 4'd3);
        highs = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bomba) highs++;
        end
        check("inv_no_request", highs, 32'd0);
        set_ch(3, 12'h010, 4'd4);
        wait_bomba(1'b1, "inv_ch3_on", n);
        check("inv_ch3_latency", n, 32'd2);
        check("inv_ch3_valvula", {28'd0, valvula}, 32'h8);
        set_ch(3, 12'h0B0, 4'd4);
        tick();
        check("inv_stop_edge", {31'd0, bomba}, 32'd1);
        tick();
        check("inv_off", {31'd0, bomba}, 32'd0);
        check("inv_falla", {28'd0, falla}, 32'd0);

        // Enable dropped at REGANDO cycle 3.
        do_reset();
        set_ch(0, 12'h010, 4'd4);
        wait_bomba(1'b1, "ab_on", n);
        tick();
        tick();
        habilitar = 1'b0;
        tick();
        check("ab_stop_edge", {31'd0, bomba}, 32'd1);
        tick();
        check("ab_off", {31'd0, bomba}, 32'd0);
        check("ab_espera", {31'd0, ocupado}, 32'd1);
        highs = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bomba) highs++;
        end
        check("ab_disabled", highs, 32'd0);
        check("ab_falla", {28'd0, falla}, 32'd0);
        habilitar = 1'b1;

        timeout_race(1'b0, "race_stop");
        timeout_race(1'b1, "race_hab");

        // Reset in the middle of a watering.
        do_reset();
        set_ch(0, 12'h010, 4'd4);
        wait_bomba(1'b1, "mid_on", n);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid_bomba", {31'd0, bomba}, 32'd0);
        check("mid_valvula", {28'd0, valvula}, 32'd0);
        check("mid_ocupado", {31'd0, ocupado}, 32'd0);
        rst = 1'b0;
        wait_bomba(1'b1, "mid_restart", n);
        check("mid_restart_lat", n, 32'd2);
        check("mid_restart_valv", {28'd0, valvula}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
